// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the register file's single write port between an ALU writeback
// requester (A) and a memory-load writeback requester (B). Each side has a
// one-entry holding buffer. The write port is driven from registers so it is
// stable when the register file commits on the falling edge.
// Optional feature: define REGARB_HAZARD_EN to enable the read-after-write
// hazard outputs; otherwise hazard1/hazard2 are tied low.

module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] wreg,
    output logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] rd_reg1,
    input  logic [ADDR_W-1:0] rd_reg2,
    output logic              hazard1,
    output logic              hazard2,
    output logic [15:0]       conflict_cnt
);

    logic              a_full;
    logic [ADDR_W-1:0] a_reg_q;
    logic [DATA_W-1:0] a_data_q;
    logic              b_full;
    logic [ADDR_W-1:0] b_reg_q;
    logic [DATA_W-1:0] b_data_q;
    logic              last;
    logic              grant_a;
    logic              grant_b;
    logic              a_take;
    logic              b_take;

    // Pick a winner: a lone full buffer wins, a tie goes to whoever was not granted last
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (a_full && b_full) begin
            grant_a = last;
            grant_b = !last;
        end else begin
            grant_a = a_full;
            grant_b = b_full;
        end
    end

    // A buffer can take a new request when empty or when it is draining this cycle
    assign a_ready = !a_full || grant_a;
    assign b_ready = !b_full || grant_b;

    // Requests to register 0 are accepted but dropped here
    assign a_take = a_valid && a_ready && (a_reg != '0);
    assign b_take = b_valid && b_ready && (b_reg != '0);

    // Requester A holding buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_full   <= 1'b0;
            a_reg_q  <= '0;
            a_data_q <= '0;
        end else if (a_take) begin
            a_full   <= 1'b1;
            a_reg_q  <= a_reg;
            a_data_q <= a_data;
        end else if (grant_a) begin
            a_full   <= 1'b0;
        end
    end

    // Requester B holding buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_full   <= 1'b0;
            b_reg_q  <= '0;
            b_data_q <= '0;
        end else if (b_take) begin
            b_full   <= 1'b1;
            b_reg_q  <= b_reg;
            b_data_q <= b_data;
        end else if (grant_b) begin
            b_full   <= 1'b0;
        end
    end

    // Registered write port and round-robin pointer (last=1 means B went last, so A wins a tie)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite <= 1'b0;
            wreg     <= '0;
            wdata    <= '0;
            last     <= 1'b1;
        end else if (grant_a) begin
            RegWrite <= 1'b1;
            wreg     <= a_reg_q;
            wdata    <= a_data_q;
            last     <= 1'b0;
        end else if (grant_b) begin
            RegWrite <= 1'b1;
            wreg     <= b_reg_q;
            wdata    <= b_data_q;
            last     <= 1'b1;
        end else begin
            RegWrite <= 1'b0;
        end
    end

    // Saturating count of cycles where both requesters were waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (a_full && b_full && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

`ifdef REGARB_HAZARD_EN
    assign hazard1 = (rd_reg1 != '0) &&
                     ((a_full && (a_reg_q == rd_reg1)) ||
                      (b_full && (b_reg_q == rd_reg1)) ||
                      (RegWrite && (wreg == rd_reg1)));
    assign hazard2 = (rd_reg2 != '0) &&
                     ((a_full && (a_reg_q == rd_reg2)) ||
                      (b_full && (b_reg_q == rd_reg2)) ||
                      (RegWrite && (wreg == rd_reg2)));
`else
    logic unused_rd;
    assign unused_rd = ^{rd_reg1, rd_reg2};
    assign hazard1   = 1'b0;
    assign hazard2   = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
// Directed and randomized stimulus against a queue-based reference model of
// the two-requester write-port arbiter. A small register file model commits
// on the falling edge. Define REGARB_HAZARD_EN to expect live hazard outputs.

module tb_regfile_write_arbiter;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } entry_t;

    logic        clk;
    logic        rst_n;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_reg;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_reg;
    logic [31:0] b_data;
    logic        RegWrite;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [4:0]  rd_reg1;
    logic [4:0]  rd_reg2;
    logic        hazard1;
    logic        hazard2;
    logic [15:0] conflict_cnt;

    int checks;
    int errors;

    // Reference model state
    entry_t      pendA[$];
    entry_t      pendB[$];
    bit          lastWasA;
    bit          expWrite;
    logic [4:0]  expWreg;
    logic [31:0] expWdata;
    int          expCnt;
    logic [31:0] refMem[32];
    logic [31:0] tbMem[32];

    regfile_write_arbiter dut (
        .clk(clk),
        .rst_n(rst_n),
        .a_valid(a_valid),
        .a_ready(a_ready),
        .a_reg(a_reg),
        .a_data(a_data),
        .b_valid(b_valid),
        .b_ready(b_ready),
        .b_reg(b_reg),
        .b_data(b_data),
        .RegWrite(RegWrite),
        .wreg(wreg),
        .wdata(wdata),
        .rd_reg1(rd_reg1),
        .rd_reg2(rd_reg2),
        .hazard1(hazard1),
        .hazard2(hazard2),
        .conflict_cnt(conflict_cnt)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model committing on the falling edge
    always @(negedge clk) begin
        if (RegWrite) tbMem[wreg] <= wdata;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic applyStimulus(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                                 input bit bv, input logic [4:0] br, input logic [31:0] bd,
                                 input logic [4:0] r1, input logic [4:0] r2);
        a_valid = av;
        a_reg   = ar;
        a_data  = ad;
        b_valid = bv;
        b_reg   = br;
        b_data  = bd;
        rd_reg1 = r1;
        rd_reg2 = r2;
    endtask

    // 0 = nobody, 1 = A, 2 = B
    function automatic int modelWinner();
        bit aHas = pendA.size() > 0;
        bit bHas = pendB.size() > 0;
        if (aHas && bHas) return lastWasA ? 2 : 1;
        if (aHas) return 1;
        if (bHas) return 2;
        return 0;
    endfunction

    function automatic bit expHazard(input logic [4:0] rd);
`ifdef REGARB_HAZARD_EN
        if (rd == 5'd0) return 1'b0;
        foreach (pendA[i]) if (pendA[i].r == rd) return 1'b1;
        foreach (pendB[i]) if (pendB[i].r == rd) return 1'b1;
        return expWrite && (expWreg == rd);
`else
        return (rd != rd);
`endif
    endfunction

    task automatic modelReset();
        pendA.delete();
        pendB.delete();
        lastWasA = 1'b0;
        expWrite = 1'b0;
        expWreg  = '0;
        expWdata = '0;
        expCnt   = 0;
    endtask

    // Advance the model across one rising edge using the currently driven inputs
    task automatic modelStep();
        int  win = modelWinner();
        bit  rdyA = (pendA.size() == 0) || (win == 1);
        bit  rdyB = (pendB.size() == 0) || (win == 2);
        entry_t e;
        if (pendA.size() > 0 && pendB.size() > 0 && expCnt < 65535) expCnt++;
        if (win == 1) begin
            e = pendA.pop_front();
            expWrite = 1'b1; expWreg = e.r; expWdata = e.d; lastWasA = 1'b1;
        end else if (win == 2) begin
            e = pendB.pop_front();
            expWrite = 1'b1; expWreg = e.r; expWdata = e.d; lastWasA = 1'b0;
        end else begin
            expWrite = 1'b0;
        end
        if (a_valid && rdyA && a_reg != 5'd0) pendA.push_back('{r: a_reg, d: a_data});
        if (b_valid && rdyB && b_reg != 5'd0) pendB.push_back('{r: b_reg, d: b_data});
    endtask

    // Check everything at mid-cycle, then step through one rising edge to the next falling edge
    task automatic runCycle(input bit resetAfterEdge);
        int win;
        #1;
        win = modelWinner();
        checkOutput("a_ready", a_ready, (pendA.size() == 0) || (win == 1));
        checkOutput("b_ready", b_ready, (pendB.size() == 0) || (win == 2));
        checkOutput("RegWrite", RegWrite, expWrite);
        checkOutput("wreg", wreg, expWreg);
        checkOutput("wdata", wdata, expWdata);
        checkOutput("conflict_cnt", conflict_cnt, expCnt);
        checkOutput("hazard1", hazard1, expHazard(rd_reg1));
        checkOutput("hazard2", hazard2, expHazard(rd_reg2));
        if (expWrite && expWreg != 5'd0) refMem[expWreg] = expWdata;
        modelStep();
        @(posedge clk);
        if (resetAfterEdge) begin
            #2 rst_n = 1'b0;
            #1;
            modelReset();
            checkOutput("rstMidRegWrite", RegWrite, 1'b0);
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) begin
            refMem[i] = '0;
            tbMem[i]  = '0;
        end
        modelReset();
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        #3;
        checkOutput("rstRegWrite", RegWrite, 1'b0);
        checkOutput("rstWreg", wreg, 5'd0);
        checkOutput("rstWdata", wdata, 32'd0);
        checkOutput("rstCnt", conflict_cnt, 16'd0);
        checkOutput("rstHaz1", hazard1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write from A to register 3, with a reader watching it
        applyStimulus(1, 5'd3, 32'hDEAD, 0, 0, 0, 5'd3, 5'd0);
        runCycle(0);
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd3, 5'd0);
        runCycle(0);
        runCycle(0);
        checkOutput("mem3", tbMem[3], 32'hDEAD);

        // Simultaneous requests: A first, then B
        applyStimulus(1, 5'd1, 32'd5, 1, 5'd2, 32'd7, 5'd1, 5'd2);
        runCycle(0);
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd1, 5'd2);
        for (int i = 0; i < 3; i++) runCycle(0);
        checkOutput("conflictOne", conflict_cnt, 16'd1);
        checkOutput("mem1", tbMem[1], 32'd5);
        checkOutput("mem2", tbMem[2], 32'd7);

        // Continuous contention with distinct registers
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 5'(8 + i), $urandom, 1, 5'(16 + i), $urandom, 5'(8 + i), 5'(16 + i));
            runCycle(0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) runCycle(0);

        // Register 0 is absorbed, then a tie shows the pointer did not move
        applyStimulus(0, 0, 0, 1, 5'd0, 32'hFFFF, 5'd0, 5'd0);
        runCycle(0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        runCycle(0);
        applyStimulus(1, 5'd5, 32'h55, 1, 5'd6, 32'h66, 5'd5, 5'd6);
        runCycle(0);
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd5, 5'd6);
        for (int i = 0; i < 3; i++) runCycle(0);

        // Same destination from both sides: later grant persists
        applyStimulus(1, 5'd7, 32'hAAAA, 1, 5'd7, 32'hBBBB, 5'd7, 5'd0);
        runCycle(0);
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd7, 5'd0);
        for (int i = 0; i < 3; i++) runCycle(0);

        // Randomized traffic on a small register range
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                          ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            runCycle(0);
        end

        // Reset mid-flight with both buffers full and a write in its high phase
        applyStimulus(1, 5'd20, 32'h1111_2222, 1, 5'd21, 32'h3333_4444, 0, 0);
        runCycle(0);
        applyStimulus(1, 5'd22, 32'h5555_6666, 1, 5'd23, 32'h7777_8888, 0, 0);
        runCycle(1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("postRstReadyA", a_ready, 1'b1);
        checkOutput("postRstReadyB", b_ready, 1'b1);
        checkOutput("postRstCnt", conflict_cnt, 16'd0);
        for (int i = 0; i < 3; i++) runCycle(0);

        // A little more random traffic after the reset
        for (int i = 0; i < 100; i++) begin
            applyStimulus(($urandom_range(0, 1) != 0), 5'($urandom_range(0, 31)), $urandom,
                          ($urandom_range(0, 1) != 0), 5'($urandom_range(0, 31)), $urandom,
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            runCycle(0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) runCycle(0);

        // Register file contents must match the model
        for (int i = 0; i < 32; i++) checkOutput($sformatf("mem%0d", i), tbMem[i], refMem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
